// File: rtl/lightbike_input_scheduler.sv
// Steering scheduler: snapshots watched PS/2 make flags, queues legal turns per player, releases one per tick.
// A key reaches the queue on the third edge after hit; a pending tick commits within 1-3 cycles of being latched.
module lightbike_input_scheduler #(
  parameter int QDEPTH = 2
) (
  input  logic         c50,
  input  logic         reset_all,
  input  logic [511:0] make_lut,
  output logic         reset_make,
  input  logic         tick,
  input  logic         round_start,
  output logic [1:0]   p1_dir,
  output logic [1:0]   p2_dir,
  output logic         step,
  output logic         paused
);

  typedef enum logic [1:0] {IDLE, CAPTURE, UPDATE} state_e;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;
  localparam logic [2:0] QD        = 3'(QDEPTH);

  state_e     state_q, state_d;
  logic [8:0] snap_q, snap_d;
  logic       reset_make_q, reset_make_d;
  logic       tick_pend_q, tick_pend_d;
  logic       paused_q, paused_d;
  logic       step_q, step_d;
  logic [1:0] dir_q [2];
  logic [1:0] dir_d [2];
  logic [1:0] fifo_q [2][QDEPTH];
  logic [1:0] fifo_d [2][QDEPTH];
  logic [2:0] cnt_q [2];
  logic [2:0] cnt_d [2];

  logic [8:0] watched;
  logic       hit;
  logic [1:0] cand [2];
  logic       cand_vld [2];
  logic [1:0] ref_dir [2];
  logic [1:0] rev_dir [2];
  logic       accept [2];
  logic       unused_make;

  // Bit order per player nibble: up, right, down, left; bit 8 is Space.
  assign watched = {make_lut[9'h029],
                    make_lut[9'h16B], make_lut[9'h172], make_lut[9'h174], make_lut[9'h175],
                    make_lut[9'h01C], make_lut[9'h01B], make_lut[9'h023], make_lut[9'h01D]};
  assign hit         = |watched;
  assign unused_make = ^make_lut;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      cand_vld[p] = |snap_q[4*p +: 4];
      cand[p]     = DIR_LEFT;
      if (snap_q[4*p+2]) cand[p] = DIR_DOWN;
      if (snap_q[4*p+1]) cand[p] = DIR_RIGHT;
      if (snap_q[4*p])   cand[p] = DIR_UP;
      ref_dir[p] = dir_q[p];
      for (int i = 0; i < QDEPTH; i++) begin
        if (int'(cnt_q[p]) == i + 1) ref_dir[p] = fifo_q[p][i];
      end
      rev_dir[p] = ref_dir[p] + 2'd2;
      accept[p]  = cand_vld[p] && (cand[p] != ref_dir[p]) && (cand[p] != rev_dir[p]) &&
                   (cnt_q[p] < QD);
    end
  end

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    reset_make_d = 1'b1;
    tick_pend_d  = tick_pend_q;
    paused_d     = paused_q;
    step_d       = 1'b0;
    dir_d        = dir_q;
    fifo_d       = fifo_q;
    cnt_d        = cnt_q;

    if (tick && !paused_q) tick_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (tick_pend_q) begin
          for (int p = 0; p < 2; p++) begin
            if (cnt_q[p] != 3'd0) begin
              dir_d[p] = fifo_q[p][0];
              for (int i = 0; i < QDEPTH - 1; i++) fifo_d[p][i] = fifo_q[p][i+1];
              cnt_d[p] = cnt_q[p] - 3'd1;
            end
          end
          step_d      = 1'b1;
          tick_pend_d = 1'b0;
        end else if (hit) begin
          // Snapshot on the edge entering CAPTURE so the table clear cannot race it.
          snap_d       = watched;
          reset_make_d = 1'b0;
          state_d      = CAPTURE;
        end
      end
      CAPTURE: state_d = UPDATE;
      UPDATE: begin
        state_d  = IDLE;
        paused_d = paused_q ^ snap_q[8];
        if (paused_d) begin
          if (!paused_q) begin
            cnt_d[0]    = 3'd0;
            cnt_d[1]    = 3'd0;
            tick_pend_d = 1'b0;
          end
        end else begin
          for (int p = 0; p < 2; p++) begin
            if (accept[p]) begin
              for (int i = 0; i < QDEPTH; i++) begin
                if (int'(cnt_q[p]) == i) fifo_d[p][i] = cand[p];
              end
              cnt_d[p] = cnt_q[p] + 3'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (round_start) begin
      state_d      = IDLE;
      snap_d       = '0;
      reset_make_d = 1'b1;
      tick_pend_d  = 1'b0;
      paused_d     = 1'b0;
      step_d       = 1'b0;
      dir_d[0]     = DIR_RIGHT;
      dir_d[1]     = DIR_LEFT;
      cnt_d[0]     = 3'd0;
      cnt_d[1]     = 3'd0;
    end
  end

  always_ff @(posedge c50 or negedge reset_all) begin
    if (!reset_all) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      reset_make_q <= 1'b1;
      tick_pend_q  <= 1'b0;
      paused_q     <= 1'b0;
      step_q       <= 1'b0;
      dir_q[0]     <= DIR_RIGHT;
      dir_q[1]     <= DIR_LEFT;
      for (int p = 0; p < 2; p++) begin
        cnt_q[p] <= '0;
        for (int i = 0; i < QDEPTH; i++) fifo_q[p][i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      reset_make_q <= reset_make_d;
      tick_pend_q  <= tick_pend_d;
      paused_q     <= paused_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      fifo_q       <= fifo_d;
      cnt_q        <= cnt_d;
    end
  end

  assign reset_make = reset_make_q;
  assign p1_dir     = dir_q[0];
  assign p2_dir     = dir_q[1];
  assign step       = step_q;
  assign paused     = paused_q;

endmodule

// File: tb/tb_lightbike_input_scheduler.sv
// Directed bench for lightbike_input_scheduler: key captures, queueing, ticks, pause and round restart.
module tb_lightbike_input_scheduler;

  logic         c50 = 1'b0;
  logic         reset_all;
  logic [511:0] make_lut;
  logic         reset_make;
  logic         tick;
  logic         round_start;
  logic [1:0]   p1_dir;
  logic [1:0]   p2_dir;
  logic         step;
  logic         paused;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 c50 = ~c50;

  lightbike_input_scheduler #(.QDEPTH(2)) dut (
    .c50        (c50),
    .reset_all  (reset_all),
    .make_lut   (make_lut),
    .reset_make (reset_make),
    .tick       (tick),
    .round_start(round_start),
    .p1_dir     (p1_dir),
    .p2_dir     (p2_dir),
    .step       (step),
    .paused     (paused)
  );

  task automatic cyc();
    @(posedge c50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] k(input int idx);
    logic [511:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // Hold the keys until the clear request appears, then let CAPTURE/UPDATE finish.
  task automatic press(input logic [511:0] keys, input string tag);
    bit seen;
    seen     = 1'b0;
    make_lut = keys;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (reset_make === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_rm_low"}, 8'(seen), 8'd1);
    make_lut = '0;
    cyc();
    chk({tag, "_rm_one_cycle"}, 8'(reset_make), 8'd1);
    cyc();
  endtask

  task automatic do_tick(input string tag, input logic [1:0] e1, input logic [1:0] e2);
    bit found;
    found = 1'b0;
    tick  = 1'b1;
    cyc();
    tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (step === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_step"}, 8'(found), 8'd1);
    chk({tag, "_p1"}, 8'(p1_dir), 8'(e1));
    chk({tag, "_p2"}, 8'(p2_dir), 8'(e2));
    cyc();
    chk({tag, "_step_one_cycle"}, 8'(step), 8'd0);
  endtask

  task automatic count_steps(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (step === 1'b1) c++;
    end
  endtask

  task automatic rs_pulse(input string tag);
    round_start = 1'b1;
    cyc();
    round_start = 1'b0;
    chk({tag, "_p1"}, 8'(p1_dir), 8'd1);
    chk({tag, "_p2"}, 8'(p2_dir), 8'd3);
  endtask

  initial begin
    int nsteps;
    reset_all   = 1'b0;
    make_lut    = '0;
    tick        = 1'b0;
    round_start = 1'b0;
    #23;
    chk("reset_p1", 8'(p1_dir), 8'd1);
    chk("reset_p2", 8'(p2_dir), 8'd3);
    chk("reset_step", 8'(step), 8'd0);
    chk("reset_paused", 8'(paused), 8'd0);
    chk("reset_rm", 8'(reset_make), 8'd1);
    cyc();
    reset_all = 1'b1;
    cyc();

    // D while already heading right: rejected as equal.
    press(k('h023), "d_eq");
    do_tick("t_eq", 2'd1, 2'd3);

    // W then S: S is the reverse of the queued tail.
    press(k('h01D), "w");
    press(k('h01B), "s_rev");
    do_tick("t_w", 2'd0, 2'd3);
    do_tick("t_empty", 2'd0, 2'd3);

    // W and A together: up has priority (left would be a reversal of right).
    rs_pulse("rs1");
    press(k('h01D) | k('h01C), "wa");
    do_tick("t_prio", 2'd0, 2'd3);

    // Player 2 fills a depth-2 queue; third press dropped.
    press(k('h175), "p2_up");
    press(k('h16B), "p2_left");
    press(k('h172), "p2_down_full");
    do_tick("t_q1", 2'd0, 2'd0);
    do_tick("t_q2", 2'd0, 2'd3);
    do_tick("t_q3", 2'd0, 2'd3);

    // Pause: ticks ignored, directions discarded.
    rs_pulse("rs2");
    press(k('h029), "space_on");
    chk("paused_on", 8'(paused), 8'd1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    count_steps(6, nsteps);
    chk("paused_no_step", 8'(nsteps), 8'd0);
    press(k('h01D), "w_paused");
    chk("paused_still", 8'(paused), 8'd1);
    press(k('h029), "space_off");
    chk("paused_off", 8'(paused), 8'd0);
    do_tick("t_unpause", 2'd1, 2'd3);

    // Round restart during CAPTURE with a tick in the same cycle.
    press(k('h01D), "w6");
    press(k('h172), "p2_down6");
    do_tick("t6a", 2'd0, 2'd2);
    press(k('h01C) | k('h174), "queue6");
    make_lut = k('h01D);
    cyc();
    chk("rs_cap_rm_low", 8'(reset_make), 8'd0);
    round_start = 1'b1;
    tick        = 1'b1;
    cyc();
    chk("rs_rm", 8'(reset_make), 8'd1);
    chk("rs_p1", 8'(p1_dir), 8'd1);
    chk("rs_p2", 8'(p2_dir), 8'd3);
    chk("rs_step", 8'(step), 8'd0);
    chk("rs_paused", 8'(paused), 8'd0);
    round_start = 1'b0;
    tick        = 1'b0;
    make_lut    = '0;
    count_steps(4, nsteps);
    chk("rs_tick_ignored", 8'(nsteps), 8'd0);
    do_tick("t6b_flushed", 2'd1, 2'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
